// File: rtl/dpram_1ton_loader.sv
// rtl/dpram_1ton_loader.sv - packs narrow beats into wide words of an inferred dual-port RAM
module dpram_1ton_loader #(
    parameter int aw     = 8,
    parameter int dw     = 8,
    parameter int expand = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [aw-expand-1:0]       base_i,
    input  logic [aw:0]                len_i,
    input  logic [dw-1:0]              din_i,
    input  logic                       din_valid_i,
    output logic                       din_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    input  logic [aw-expand-1:0]       raddr_i,
    output logic [(dw<<expand)-1:0]    rdata_o
);
    localparam int awb   = aw - expand;
    localparam int dwb   = dw << expand;
    localparam int n     = 1 << expand;
    localparam int depth = 1 << awb;

    localparam logic [aw:0]       LEN_MAX   = {1'b1, {aw{1'b0}}};
    localparam logic [aw:0]       REM_ONE   = {{aw{1'b0}}, 1'b1};
    localparam logic [expand-1:0] LANE_LAST = '1;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state_q, state_d;
    logic [awb-1:0]    wptr_q, wptr_d;
    logic [expand-1:0] lane_q, lane_d;
    logic [dwb-1:0]    asm_q, asm_d;
    logic [aw:0]       rem_q, rem_d;
    logic [dwb-1:0]    rdata_q;
    logic [dwb-1:0]    word;
    logic [aw:0]       len_clamp;
    logic              beat;
    logic              we;

    logic [dwb-1:0] mem [depth];

    assign len_clamp = (len_i > LEN_MAX) ? LEN_MAX : len_i;

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        lane_d      = lane_q;
        asm_d       = asm_q;
        rem_d       = rem_q;
        we          = 1'b0;
        din_ready_o = (state_q == FILL);
        busy_o      = (state_q == FILL);
        done_o      = (state_q == DONE);
        beat        = din_ready_o & din_valid_i;

        // Current beat merged into its lane so the final write includes it
        word = asm_q;
        for (int k = 0; k < n; k++) begin
            if (lane_q == expand'(k)) begin
                word[k*dw +: dw] = din_i;
            end
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    wptr_d  = base_i;
                    lane_d  = '0;
                    asm_d   = '0;
                    rem_d   = len_clamp;
                    state_d = (len_clamp == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (beat) begin
                    rem_d = rem_q - 1'b1;
                    if (lane_q == LANE_LAST || rem_q == REM_ONE) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        lane_d = '0;
                        asm_d  = '0;
                    end else begin
                        lane_d = lane_q + 1'b1;
                        asm_d  = word;
                    end
                    if (rem_q == REM_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            rem_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            rem_q   <= rem_d;
            rdata_q <= mem[raddr_i];
        end
    end

    // Storage is never cleared; reset only suppresses the write in flight
    always_ff @(posedge clk_i) begin
        if (we && !rst_i) begin
            mem[wptr_q] <= word;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dpram_1ton_loader.sv
// tb/tb_dpram_1ton_loader.sv - randomized self-checking bench with a word-level memory model
module tb_dpram_1ton_loader;
    localparam int AW = 8, DW = 8, EXP = 3;
    localparam int N = 8, AWB = 5, DWB = 64, DEPTH = 32, LMAX = 256;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic [AWB-1:0] base_i = '0;
    logic [AW:0]    len_i = '0;
    logic [DW-1:0]  din_i = '0;
    logic           din_valid_i = 1'b0;
    logic           din_ready_o, busy_o, done_o;
    logic [AWB-1:0] raddr_i = '0;
    logic [DWB-1:0] rdata_o;

    logic [DWB-1:0] model [DEPTH];
    int checks = 0;
    int errors = 0;

    dpram_1ton_loader #(.aw(AW), .dw(DW), .expand(EXP)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_i(base_i),
        .len_i(len_i), .din_i(din_i), .din_valid_i(din_valid_i),
        .din_ready_o(din_ready_o), .busy_o(busy_o), .done_o(done_o),
        .raddr_i(raddr_i), .rdata_o(rdata_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input int b, input int l, input logic [7:0] q[$]);
        logic [63:0] w;
        for (int i = 0; i < (l + N - 1) / N; i++) begin
            w = '0;
            for (int k = 0; k < N; k++) begin
                if (i * N + k < l) w[k*8 +: 8] = q[i*N + k];
            end
            model[(b + i) % DEPTH] = w;
        end
    endtask

    task automatic check_mem(input string tag);
        @(negedge clk);
        raddr_i = '0;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            check(tag, rdata_o, model[a]);
            raddr_i = AWB'(a + 1);
        end
    endtask

    task automatic read_check(input string tag, input int a, input logic [63:0] exp);
        @(negedge clk);
        raddr_i = AWB'(a);
        @(negedge clk);
        check(tag, rdata_o, exp);
    endtask

    task automatic run_load(input int b, input int len_req, input int gap_pct,
                            input bit seq, input bit inject);
        logic [7:0] q[$];
        int l, idx, cyc, budget;
        bit injected;
        l = (len_req > LMAX) ? LMAX : len_req;
        for (int i = 0; i < l; i++) q.push_back(seq ? 8'(i + 1) : 8'($urandom));
        @(negedge clk);
        check("idle_busy", busy_o, 0);
        start_i = 1'b1;
        base_i  = AWB'(b);
        len_i   = 9'(len_req);
        @(negedge clk);
        start_i = 1'b0;
        base_i  = AWB'($urandom);
        len_i   = 9'($urandom);
        idx = 0; cyc = 0; injected = 1'b0;
        budget = 4 * l + 100;
        while (idx < l) begin
            check("fill_ready", din_ready_o, 1);
            check("fill_busy", busy_o, 1);
            check("fill_done", done_o, 0);
            if (inject && !injected && idx >= l / 2) begin
                start_i  = 1'b1;
                injected = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            din_valid_i = ($urandom_range(99) >= gap_pct);
            din_i       = din_valid_i ? q[idx] : 8'($urandom);
            if (din_valid_i) idx++;
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                check("fill_timeout", cyc, budget);
                break;
            end
        end
        din_valid_i = 1'b0;
        start_i     = 1'b0;
        check("done_pulse", done_o, 1);
        check("done_busy", busy_o, 0);
        check("done_ready", din_ready_o, 0);
        @(negedge clk);
        check("done_once", done_o, 0);
        check("after_busy", busy_o, 0);
        model_load(b, l, q);
    endtask

    initial begin
        int b, l;
        repeat (3) @(negedge clk);
        check("rst_ready", din_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_rdata", rdata_o, 0);
        rst_i = 1'b0;

        run_load(0, 256, 0, 1'b0, 1'b0);
        check_mem("prefill");

        run_load(0, 8, 0, 1'b1, 1'b0);
        read_check("b2b_word0", 0, 64'h0807060504030201);
        check_mem("b2b_mem");

        run_load(3, 11, 0, 1'b1, 1'b0);
        read_check("len11_word3", 3, 64'h0807060504030201);
        read_check("len11_word4", 4, 64'h00000000000B0A09);
        check_mem("len11_mem");

        run_load(31, 16, 0, 1'b1, 1'b0);
        read_check("wrap_word31", 31, 64'h0807060504030201);
        read_check("wrap_word0", 0, 64'h100F0E0D0C0B0A09);
        check_mem("wrap_mem");

        run_load(9, 0, 0, 1'b1, 1'b0);
        check_mem("len0_mem");

        run_load(0, 8, 0, 1'b0, 1'b0);
        run_load(0, 8, 40, 1'b1, 1'b1);
        read_check("gap_word0", 0, 64'h0807060504030201);
        check_mem("gap_mem");

        @(negedge clk);
        start_i = 1'b1; base_i = 5'd7; len_i = 9'd8;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din_valid_i = 1'b1;
            din_i = 8'($urandom);
            @(negedge clk);
        end
        rst_i = 1'b1; start_i = 1'b1; din_valid_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0; start_i = 1'b0; din_valid_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_ready", din_ready_o, 0);
        check("abort_done", done_o, 0);
        check("abort_rdata", rdata_o, 0);
        repeat (5) begin
            @(negedge clk);
            check("abort_no_done", done_o, 0);
        end
        check_mem("abort_mem");
        run_load(7, 8, 20, 1'b1, 1'b0);
        read_check("post_abort_word7", 7, 64'h0807060504030201);

        run_load(5, 400, 10, 1'b0, 1'b0);
        check_mem("clamp_mem");

        for (int t = 0; t < 6; t++) begin
            b = int'($urandom_range(DEPTH - 1));
            l = int'($urandom_range(40, 1));
            run_load(b, l, int'($urandom_range(50)), 1'b0, t[0]);
            check_mem("rand_mem");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dpram_1ton_loader.md
DPRAM_1TON_LOADER -- requirements
Module: dpram_1toN_loader

Interface
REQ-001 Parameter aw, default 8, narrow (per-beat) address width.
REQ-002 Parameter dw, default 8, narrow data width.
REQ-003 Parameter expand, default 3, log2 of packing ratio; N=2^expand, awb=aw-expand, dwb=dw<<expand.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle load request, sampled only in IDLE.
REQ-008 base  in  awb  wide-word start address, captured on accepted start.
REQ-009 len  in  aw+1  load length in narrow words, captured on accepted start.
REQ-010 din  in  dw  narrow write data.
REQ-011 din_valid  in  1  din qualifier.
REQ-012 din_ready  out  1  loader accepts din this cycle.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 raddr  in  awb  wide read address.
REQ-016 rdata  out  dwb  wide read data.

Function
REQ-017 Internal memory SHALL be 2^awb words of dwb bits, single clock, inferred.
REQ-018 States SHALL be IDLE, FILL, DONE; start in IDLE -> FILL (or DONE if captured len=0); start outside IDLE ignored.
REQ-019 Captured len above 2^aw SHALL be clamped to 2^aw.
REQ-020 din_ready SHALL be 1 exactly while in FILL; beat accepted when din_valid & din_ready.
REQ-021 Beat k of a wide word (lane counter k, 0..N-1) SHALL occupy bits [(k+1)*dw-1 : k*dw], lane 0 first (inverse of the wide-write/narrow-read lane map).
REQ-022 On the edge accepting lane N-1, or the final beat of len, the assembled word including the current din SHALL be written to mem[wptr] on that same edge; unfilled lanes written as zero.
REQ-023 wptr SHALL load base on start, increment by 1 after each wide write, wrap modulo 2^awb; lane counter resets to 0 after each write.
REQ-024 Number of wide writes per load SHALL equal ceil(len/N); no other memory writes occur.
REQ-025 Assembly register SHALL be cleared after each wide write.
REQ-026 After the final write, FSM SHALL enter DONE for exactly one cycle: done=1, busy=0, then IDLE.
REQ-027 busy SHALL be 1 in FILL only; start accepted in the cycle DONE is exited is not allowed (DONE is not IDLE).
REQ-028 rdata SHALL be registered: rdata = mem[raddr] one cycle after raddr presented; read-during-write to same address returns old data.
REQ-029 Gaps in din_valid SHALL stall packing without loss or duplication.

Reset
REQ-030 On rst: state IDLE, din_ready=0, busy=0, done=0, rdata=0, lane counter=0, assembly register=0, wptr=0.
REQ-031 Memory contents SHALL NOT be reset; rst mid-load aborts, completed wide writes remain, partial word discarded.
REQ-032 rst SHALL take priority over start and din in the same cycle.

Verification (aw=8, dw=8, expand=3: N=8, dwb=64, awb=5)
REQ-033 start base=0 len=8, din 0x01..0x08 back-to-back -> mem[0]=0x0807060504030201, done one cycle after 8th beat, raddr=0 gives that rdata next cycle.
REQ-034 base=3 len=11, din 0x01..0x0B -> mem[3]=0x0807060504030201, mem[4]=0x00000000000B0A09, exactly 2 writes, one done pulse.
REQ-035 base=31 len=16 -> mem[31] holds beats 1-8, mem[0] holds beats 9-16 (wrap).
REQ-036 len=0 -> done one cycle after start, din_ready never asserted, no memory change.
REQ-037 Case REQ-033 with random din_valid gaps and a second start mid-FILL -> identical memory result, second start ignored.
REQ-038 rst after 3 accepted beats -> next cycle busy=0, din_ready=0, done never pulses, mem[base] unchanged; subsequent load completes normally.
